td_window_reader: RTL and testbench
===================================

Name: td_window_reader

Overview:
- Read-side companion to the time-domain circular sample buffer. The buffer writes led1 samples into the dual-port RAM on port A.
- On each new-sample strobe, this block reads the most recent WIN samples out of RAM port B, oldest to newest, with wrap-around.
- It streams the samples downstream on a valid/ready handshake and reports the window's signed max and min when the pass completes.

Parameters:
- DEPTH, 1503: number of RAM entries in the circular region; the write pointer runs 0..DEPTH-1.
- WIN, 1500: samples per window pass.
- AW, 11: RAM address width.
- DW, 22: sample width, two's complement.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle new-sample strobe from the buffer writer.
- wr_ptr  in  12  writer's next-write index, valid in the start cycle; the newest sample is at (wr_ptr-1) mod DEPTH.
- rd_addr  out  AW  RAM port B address.
- rd_data  in  DW  RAM port B data, one cycle after rd_addr.
- out_sample  out  DW  streamed sample (signed).
- out_valid  out  1  out_sample valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  marks the final (newest) sample of the pass; qualified by out_valid.
- win_max  out  DW  signed max of the last completed pass.
- win_min  out  DW  signed min of the last completed pass.
- stats_valid  out  1  one-cycle pulse when win_max/win_min update.
- busy  out  1  pass in progress.
- overrun  out  1  sticky error flag.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE.
- Reset asserted mid-pass: the pass is abandoned, with no stats_valid and no further out_valid.
- States:
  - IDLE: on start with wr_ptr<DEPTH, latch base=(wr_ptr+DEPTH-WIN) mod DEPTH, clear the counter, set busy, go to WAIT.
  - WAIT: 2 cycles, covering the writer's registered address plus the RAM write. Then ISSUE.
  - ISSUE: drive rd_addr=ptr. Go to CAPTURE.
  - CAPTURE: register rd_data into out_sample. Go to PRESENT.
  - PRESENT: out_valid=1, with out_last=1 when cnt==WIN-1. Hold out_sample/out_valid/out_last stable until out_ready. On handshake: update max/min, ptr=(ptr==DEPTH-1)?0:ptr+1, cnt+=1. Then ISSUE, or DONE if cnt was WIN-1.
  - DONE: win_max/win_min <= running values, stats_valid=1 for this one cycle, busy=0, go to IDLE.
- Timing:
  - start in cycle t: first rd_addr in t+3, first out_valid in t+5.
  - With out_ready held high: one sample per 3 cycles; pass end (DONE) at t+3+3*WIN.
- Running max/min:
  - Signed compare.
  - Initialised from the first accepted sample, not from 0.
  - win_max/win_min hold their previous values until DONE.
- rd_addr holds its last value outside ISSUE.
- Boundaries:
  - Address wraps DEPTH-1 → 0 mid-pass.
  - wr_ptr=0 is valid: newest sample at DEPTH-1.
- start while busy: ignored, overrun <= 1; the current pass continues unaffected.
- start with wr_ptr>=DEPTH: ignored, overrun <= 1.
- overrun clears only on reset.
- start in the same cycle as DONE: ignored and flagged, since busy is still 1 in that cycle.
- out_ready asserted while out_valid=0: no effect.

Test Plan:
- Preload RAM[i]=i. start with wr_ptr=1502, out_ready=1. Expect:
  - 1500 samples, values 2..1501 in order;
  - out_last only on 1501;
  - first out_valid 5 cycles after start;
  - stats_valid once, with win_max=1501, win_min=2.
- Wrap: RAM[i]=i, start with wr_ptr=5. Expect:
  - stream 8..1502, then 0..4 (1500 samples);
  - out_last on 4;
  - win_max=1502, win_min=0.
- Signed extremes: RAM all 0 except RAM[100]=-2097152 (0x200000) and RAM[700]=2097151. Start with wr_ptr=1502. Expect win_min=-2097152, win_max=2097151.
- Backpressure: random out_ready, 30% duty. Expect:
  - same 2..1501 sequence with no drops or duplicates;
  - out_sample stable while out_valid && !out_ready.
- Second start issued 100 cycles into a pass. Expect:
  - overrun=1;
  - pass completes normally with 1500 samples;
  - the next start after DONE runs a fresh pass.
- Reset asserted at sample 700 of a pass. Expect:
  - next cycle all outputs 0, no stats_valid;
  - a subsequent start with wr_ptr=1502 gives a clean full pass.

Source files
------------

// File: rtl/td_window_reader.sv
// td_window_reader
//   Read-side companion to the time-domain circular sample buffer. The block
//   starts on each new-sample strobe. It reads the most recent WIN samples from
//   RAM port B, oldest to newest, wrapping at DEPTH-1. It streams them out on a
//   valid/ready handshake. When the pass finishes it reports the signed max and
//   min of the window.
//
// Ports
//   clk, reset        system clock; synchronous active-high reset
//   start, wr_ptr     new-sample strobe and the writer's next-write index
//   rd_addr, rd_data  RAM port B (data arrives one cycle after address)
//   out_sample/out_valid/out_ready/out_last  sample stream, last = newest
//   win_max, win_min, stats_valid            window statistics + update pulse
//   busy, overrun     pass in progress; sticky ignored-start flag
module td_window_reader #(
  parameter int unsigned DEPTH = 1503,
  parameter int unsigned WIN   = 1500,
  parameter int unsigned AW    = 11,
  parameter int unsigned DW    = 22
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [11:0]   wr_ptr,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] out_sample,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [DW-1:0] win_max,
  output logic [DW-1:0] win_min,
  output logic          stats_valid,
  output logic          busy,
  output logic          overrun
);

  localparam int unsigned CW = $clog2(WIN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_A,
    S_WAIT_B,
    S_ISSUE,
    S_CAPTURE,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [AW-1:0]        r_ptr;
  logic [AW-1:0]        r_addr;
  logic [CW-1:0]        r_cnt;
  logic [DW-1:0]        r_sample;
  logic [DW-1:0]        r_run_max;
  logic [DW-1:0]        r_run_min;
  logic [DW-1:0]        r_win_max;
  logic [DW-1:0]        r_win_min;
  logic                 r_overrun;

  logic [12:0]          w_base_sum;
  logic [AW-1:0]        w_base;
  logic                 w_start_ok;
  logic                 w_last_cnt;
  logic                 w_hs;
  logic signed [DW-1:0] w_s;
  logic [DW-1:0]        w_new_max;
  logic [DW-1:0]        w_new_min;

  // wr_ptr < DEPTH, so the sum is below 2*DEPTH and one conditional subtract
  // gives the modulo.
  always_comb begin
    w_base_sum = {1'b0, wr_ptr} + 13'(DEPTH - WIN);
    w_base     = (w_base_sum >= 13'(DEPTH)) ? AW'(w_base_sum - 13'(DEPTH))
                                            : AW'(w_base_sum);
  end

  assign w_start_ok = start && (r_state == S_IDLE) && ({1'b0, wr_ptr} < 13'(DEPTH));
  assign w_last_cnt = (r_cnt == CW'(WIN - 1));
  assign w_hs       = (r_state == S_PRESENT) && out_ready;

  // The first accepted sample seeds the running extremes (r_cnt == 0).
  always_comb begin
    w_s       = $signed(r_sample);
    w_new_max = ((r_cnt == '0) || (w_s > $signed(r_run_max))) ? r_sample : r_run_max;
    w_new_min = ((r_cnt == '0) || (w_s < $signed(r_run_min))) ? r_sample : r_run_min;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start_ok) w_next = S_WAIT_A;
      S_WAIT_A:  w_next = S_WAIT_B;
      S_WAIT_B:  w_next = S_ISSUE;
      S_ISSUE:   w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_PRESENT;
      S_PRESENT: if (out_ready) w_next = w_last_cnt ? S_DONE : S_ISSUE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr     <= '0;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_sample  <= '0;
      r_run_max <= '0;
      r_run_min <= '0;
      r_win_max <= '0;
      r_win_min <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_ptr <= w_base;
        r_cnt <= '0;
      end
      // Covers both a start during a pass (including DONE) and an out-of-range wr_ptr.
      if (start && !w_start_ok) r_overrun <= 1'b1;
      if (r_state == S_ISSUE)   r_addr    <= r_ptr;
      if (r_state == S_CAPTURE) r_sample  <= rd_data;
      if (w_hs) begin
        r_run_max <= w_new_max;
        r_run_min <= w_new_min;
        r_ptr     <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
        r_cnt     <= r_cnt + 1'b1;
        // The window results are published on the final handshake so that they
        // are already valid in the DONE cycle, alongside stats_valid.
        if (w_last_cnt) begin
          r_win_max <= w_new_max;
          r_win_min <= w_new_min;
        end
      end
    end
  end

  // The held address is only refreshed at the end of ISSUE, so the port is
  // driven directly from r_ptr during ISSUE.
  assign rd_addr     = (r_state == S_ISSUE) ? r_ptr : r_addr;
  assign out_sample  = r_sample;
  assign out_valid   = (r_state == S_PRESENT);
  assign out_last    = (r_state == S_PRESENT) && w_last_cnt;
  assign win_max     = r_win_max;
  assign win_min     = r_win_min;
  assign stats_valid = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_td_window_reader.sv
// Testbench for td_window_reader. It models RAM port B and drives
// directed/random window passes. Each stream is checked against a window
// computed directly from RAM contents.
module tb_td_window_reader;

  localparam int DEPTH = 1503;
  localparam int WIN   = 1500;
  localparam int AW    = 11;
  localparam int DW    = 22;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [11:0]   wr_ptr;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] out_sample;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [DW-1:0] win_max;
  logic [DW-1:0] win_min;
  logic          stats_valid;
  logic          busy;
  logic          overrun;

  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] m_max, m_min;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int            wp;
    int            fill;
    int            duty;
    logic [DW-1:0] e_first;
    logic [DW-1:0] e_last;
    logic [DW-1:0] e_max;
    logic [DW-1:0] e_min;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (int'(rd_addr) < DEPTH) rd_data <= ram[rd_addr];
  end

  td_window_reader #(
    .DEPTH(DEPTH),
    .WIN  (WIN),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .wr_ptr     (wr_ptr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_sample (out_sample),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .win_max    (win_max),
    .win_min    (win_min),
    .stats_valid(stats_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_addr"},     32'(rd_addr),     0);
    chk({tag, "_out_sample"},  32'(out_sample),  0);
    chk({tag, "_out_valid"},   32'(out_valid),   0);
    chk({tag, "_out_last"},    32'(out_last),    0);
    chk({tag, "_win_max"},     32'(win_max),     0);
    chk({tag, "_win_min"},     32'(win_min),     0);
    chk({tag, "_stats_valid"}, 32'(stats_valid), 0);
    chk({tag, "_busy"},        32'(busy),        0);
    chk({tag, "_overrun"},     32'(overrun),     0);
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < DEPTH; i++) begin
      case (mode)
        0:       ram[i] = DW'(i);
        1:       ram[i] = '0;
        default: ram[i] = DW'($urandom);
      endcase
    end
    if (mode == 1) begin
      ram[100] = 22'h200000;
      ram[700] = 22'h1FFFFF;
    end
  endtask

  // Window = the WIN entries ending just before wr_ptr, oldest first.
  task automatic build_model(input int wp);
    exp_q.delete();
    for (int k = 0; k < WIN; k++) exp_q.push_back(ram[(wp + DEPTH - WIN + k) % DEPTH]);
    m_max = exp_q[0];
    m_min = exp_q[0];
    foreach (exp_q[i]) begin
      if ($signed(exp_q[i]) > $signed(m_max)) m_max = exp_q[i];
      if ($signed(exp_q[i]) < $signed(m_min)) m_min = exp_q[i];
    end
  endtask

  task automatic run_pass(input int wp, input int duty, input int rst_at,
                          input int second_at, input bit start_at_done,
                          output logic [DW-1:0] f_first, output logic [DW-1:0] f_lastv,
                          output logic [DW-1:0] f_max, output logic [DW-1:0] f_min);
    int            idx = 0;
    int            nstats = 0;
    int            stats_k = -1;
    int            base;
    int            noise;
    bit            stall = 0;
    bit            held_last = 0;
    bit            done = 0;
    bit            rst_hit = 0;
    logic [DW-1:0] held = '0;

    build_model(wp);
    base    = (wp + DEPTH - WIN) % DEPTH;
    f_first = '0;
    f_lastv = '0;
    f_max   = '0;
    f_min   = '0;

    @(negedge clk);
    start     = 1'b1;
    wr_ptr    = 12'(wp);
    out_ready = 1'b0;

    for (int k = 1; k <= 20 * WIN + 100 && !done; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 1) chk("busy_after_start", 32'(busy), 1);
      if (k == 3) chk("first_rd_addr", 32'(rd_addr), 32'(base));
      if (k == 4) chk("no_valid_before_t5", 32'(out_valid), 0);
      if (k == 5) chk("first_valid_t5", 32'(out_valid), 1);
      if (k == second_at) begin
        start  = 1'b1;
        wr_ptr = 12'd7;
      end
      if (stall) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_sample", 32'(out_sample), 32'(held));
        chk("stall_last", 32'(out_last), 32'(held_last));
      end
      out_ready = ($urandom_range(0, 99) < duty);
      stall     = out_valid && !out_ready;
      held      = out_sample;
      held_last = out_last;
      if (out_valid && out_ready) begin
        if (idx < WIN) begin
          chk("sample", 32'(out_sample), 32'(exp_q[idx]));
          chk("last_flag", 32'(out_last), 32'(idx == WIN - 1));
        end else begin
          chk("extra_sample_idx", 32'(idx), 32'(WIN - 1));
        end
        if (idx == 0) f_first = out_sample;
        if (out_last) f_lastv = out_sample;
        idx++;
      end
      if (stats_valid) begin
        nstats++;
        if (nstats == 1) begin
          stats_k = k;
          f_max   = win_max;
          f_min   = win_min;
          chk("samples_at_stats", 32'(idx), 32'(WIN));
          if (duty >= 100) chk("done_cycle", 32'(k), 32'(3 + 3 * WIN));
          if (start_at_done) begin
            chk("overrun_before_done_start", 32'(overrun), 0);
            start  = 1'b1;
            wr_ptr = 12'd1502;
          end
        end
      end
      if (stats_k > 0 && k == stats_k + 1) chk("busy_after_done", 32'(busy), 0);
      if (stats_k > 0 && k == stats_k + 3) begin
        if (start_at_done) begin
          chk("overrun_after_done_start", 32'(overrun), 1);
          chk("done_start_ignored", 32'(busy), 0);
        end
        done = 1'b1;
      end
      if (rst_at >= 0 && idx == rst_at) begin
        reset     = 1'b1;
        out_ready = 1'b0;
        rst_hit   = 1'b1;
        break;
      end
    end

    if (rst_at >= 0) begin
      chk("reset_point_reached", 32'(rst_hit), 1);
      @(negedge clk);
      chk_all_zero("midreset");
      reset = 1'b0;
      noise = 0;
      repeat (12) begin
        @(negedge clk);
        if (out_valid || stats_valid || busy) noise++;
      end
      chk("quiet_after_reset", 32'(noise), 0);
    end else begin
      chk("pass_completed", 32'(done), 1);
      chk("sample_count", 32'(idx), 32'(WIN));
      chk("stats_pulses", 32'(nstats), 1);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] g_first, g_last, g_max, g_min;
    int            wp, busy_seen;

    reset     = 1'b1;
    start     = 1'b0;
    wr_ptr    = '0;
    out_ready = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    vecs[0] = '{1502, 0, 100, 22'd2, 22'd1501, 22'd1501, 22'd2};
    vecs[1] = '{5,    0, 100, 22'd8, 22'd4,    22'd1502, 22'd0};
    vecs[2] = '{1502, 1, 100, 22'd0, 22'd0,    22'h1FFFFF, 22'h200000};
    vecs[3] = '{1502, 0, 30,  22'd2, 22'd1501, 22'd1501, 22'd2};
    vecs[4] = '{0,    0, 100, 22'd3, 22'd1502, 22'd1502, 22'd3};

    foreach (vecs[i]) begin
      fill(vecs[i].fill);
      run_pass(vecs[i].wp, vecs[i].duty, -1, -1, 1'b0, g_first, g_last, g_max, g_min);
      chk($sformatf("v%0d_first", i), 32'(g_first), 32'(vecs[i].e_first));
      chk($sformatf("v%0d_last", i),  32'(g_last),  32'(vecs[i].e_last));
      chk($sformatf("v%0d_max", i),   32'(g_max),   32'(vecs[i].e_max));
      chk($sformatf("v%0d_min", i),   32'(g_min),   32'(vecs[i].e_min));
      chk($sformatf("v%0d_overrun", i), 32'(overrun), 0);
    end

    // Second start 100 cycles into a pass.
    fill(0);
    run_pass(1502, 100, -1, 100, 1'b0, g_first, g_last, g_max, g_min);
    chk("second_start_overrun", 32'(overrun), 1);
    chk("second_start_max", 32'(g_max), 1501);
    chk("second_start_min", 32'(g_min), 2);

    // Fresh passes after that, random data/pointer/backpressure.
    for (int r = 0; r < 2; r++) begin
      fill(2);
      wp = int'($urandom_range(0, DEPTH - 1));
      run_pass(wp, 60, -1, -1, 1'b0, g_first, g_last, g_max, g_min);
      chk("rand_first", 32'(g_first), 32'(exp_q[0]));
      chk("rand_last",  32'(g_last),  32'(exp_q[WIN - 1]));
      chk("rand_max",   32'(g_max),   32'(m_max));
      chk("rand_min",   32'(g_min),   32'(m_min));
    end

    // Reset at sample 700, then a clean pass with a start landing on DONE.
    fill(0);
    run_pass(1502, 100, 700, -1, 1'b0, g_first, g_last, g_max, g_min);
    run_pass(1502, 100, -1, -1, 1'b1, g_first, g_last, g_max, g_min);
    chk("clean_first", 32'(g_first), 2);
    chk("clean_last",  32'(g_last),  1501);
    chk("clean_max",   32'(g_max),   1501);
    chk("clean_min",   32'(g_min),   2);

    // Out-of-range wr_ptr.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    start  = 1'b1;
    wr_ptr = 12'd1503;
    busy_seen = 0;
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
      if (busy || out_valid) busy_seen++;
    end
    chk("bad_ptr_ignored", 32'(busy_seen), 0);
    chk("bad_ptr_overrun", 32'(overrun), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
